// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the execute stage: one bit per cycle,
// shift-add multiply or restoring divide, with sign fix-up and divide special cases.
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_in_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_out_o,
    output logic [1:0]      state_o
);

    // Handshake: start_i is taken only in IDLE without flush_i; stall_o holds the
    // operands upstream until the result, and done_o pulses once with result_o/rd_out_o.
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
    localparam int CW = $clog2(XLEN);

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              is_div, a_signed, b_signed, a_neg, b_neg, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   div_part, fix_res;

    always_comb begin
        is_div   = op_i[2];
        a_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'd1 || op_i[1:0] == 2'd2);
        b_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'd1);
        a_neg    = a_signed & rs1_data_i[XLEN-1];
        b_neg    = b_signed & rs2_data_i[XLEN-1];
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
        // Remainder takes the dividend's sign; quotient and product take the xor.
        neg_d    = (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero = is_div && (rs2_data_i == '0);
        div_ovf  = is_div && !op_i[0] && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_data_i == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = op_i[1] ? rs1_data_i : '1;
        else          special_res = op_i[1] ? '0 : rs1_data_i;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod_fix = neg_q ? -acc_q : acc_q;
        div_part = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (op_q[2])              fix_res = neg_q ? -div_part : div_part;
        else if (op_q[1:0] == '0) fix_res = prod_fix[XLEN-1:0];
        else                      fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    assign stall_o  = (state_q == S_IDLE && start_i && !flush_i && !special)
                      || state_q == S_CALC || state_q == S_FIX;
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign rd_out_o = rd_out_q;
    assign state_o  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    op_q <= op_i;
                    rd_q <= rd_in_i;
                    if (special) begin
                        result_q <= special_res;
                        rd_out_q <= rd_in_i;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q   <= {{XLEN{1'b0}}, a_mag};
                        opb_q   <= b_mag;
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    rd_out_q <= rd_q;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized and directed bench for ex_mdu against an arithmetic reference model
// with a per-cycle compare of stall, done, result and rd_out.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic [1:0]  state_dbg;

    ex_mdu dut (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .rs1_data_i(rs1),
        .rs2_data_i(rs2), .rd_in_i(rd_in), .flush_i(flush), .stall_o(stall),
        .done_o(done), .result_o(result), .rd_out_o(rd_out), .state_o(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arithmetic
    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a};  ub = {32'b0, b};
        ia = a; ib = b;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return ia / ib;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                  else return ia % ib;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // latency model: 33 busy cycles after acceptance, then one done cycle
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] held_res = '0;
    logic [4:0]  held_rd = '0;
    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_left = 0; held_res = '0; held_rd = '0;
            exp_q.delete(); exp_rd_q.delete();
        end else if (flush) begin
            m_busy = 0; exp_q.delete(); exp_rd_q.delete();
        end else if (m_busy) begin
            if (m_left == 0) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0 && exp_q.size() > 0) begin
                    held_res = exp_q.pop_front();
                    held_rd  = exp_rd_q.pop_front();
                end
            end
        end else if (start) begin
            m_busy = 1;
            exp_q.push_back(ref_result(op, rs1, rs2));
            exp_rd_q.push_back(rd_in);
            if (is_special(op, rs1, rs2)) begin
                m_left   = 0;
                held_res = exp_q.pop_front();
                held_rd  = exp_rd_q.pop_front();
            end else begin
                m_left = 33;
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        logic exp_stall, exp_done;
        exp_stall = !rst && ((!m_busy && start && !flush && !is_special(op, rs1, rs2))
                             || (m_busy && m_left > 0));
        exp_done  = !rst && m_busy && m_left == 0;
        check("stall", {31'b0, stall}, {31'b0, exp_stall});
        check("done", {31'b0, done}, {31'b0, exp_done});
        check("result", result, held_res);
        check("rd_out", {27'b0, rd_out}, {27'b0, held_rd});
    end

    // driver tasks
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int stall_cnt);
        bit got;
        got = 0; lat = 0; stall_cnt = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (stall === 1'b1) stall_cnt++;
            if (done === 1'b1) got = 1;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                       input int exp_lat);
        int lat, sc;
        issue(o, a, b, r);
        wait_done(lat, sc);
        check({name, "_lat"}, lat, exp_lat);
        check(name, result, exp);
        check({name, "_rd"}, {27'b0, rd_out}, {27'b0, r});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int lat, sc;
        logic [2:0]  o;
        logic [31:0] a, b;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'b0, rd_out}, 32'd0);

        check("pin_mul", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("pin_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        check("pin_rem", ref_result(3'd6, -32'd7, 32'd2), 32'hFFFF_FFFF);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(lat, sc);
        check("mul_lat", lat, 34);
        check("mul_stall_cycles", sc, 33);
        check("mul", result, 32'hFFFF_FFEB);
        check("mul_rd", {27'b0, rd_out}, 32'd5);

        run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 34);
        run("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0, 34);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 34);
        run("div", 3'd4, -32'd7, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
        run("rem", 3'd6, -32'd7, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
        run("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34);
        run("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34);
        run("div0", 3'd4, 32'd9, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
        run("rem0", 3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 1);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 1);

        // flush in the tenth CALC cycle
        issue(3'd5, 32'd1000, 32'd7, 5'd20);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'b0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        run("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd21, 32'd3, 34);

        // flush together with start
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd6; rs2 = 32'd6; rd_in = 5'd22;
        @(negedge clk);
        check("flush_start_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_start_result", result, 32'd3);

        // asynchronous reset mid-CALC
        issue(3'd0, 32'h1234, 32'h5678, 5'd9);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_stall", {31'b0, stall}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_rd", {27'b0, rd_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        run("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 34);

        // randomized back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run("rand", o, a, b, 5'($urandom_range(0, 31)), ref_result(o, a, b),
                is_special(o, a, b) ? 1 : 34);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
